// File: rtl/vga_pixel_assembler_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_assembler_if
//  Description : Bundle between the RAM reader / VGA stage side and the pixel
//                assembler.
//                  byte_in      - byte returned by the frame-buffer reader
//                  refresh_data - byte request towards the reader
//                  pixel_req    - one-cycle pop strobe from the VGA stage
//                  rgb          - popped pixel {R,G,B}
//                  pixel_valid  - rgb holds a real pixel this cycle
//                  underflow    - sticky empty-pop flag
//                  fifo_level   - pixel FIFO occupancy
//                  frame_done   - pulse on the last pixel of a frame
//                The assembler connects through the slave modport; the
//                environment (reader + VGA stage) uses the master modport.
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_pixel_assembler_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]         byte_in;
    logic               refresh_data;
    logic               pixel_req;
    logic [23:0]        rgb;
    logic               pixel_valid;
    logic               underflow;
    logic [LEVEL_W-1:0] fifo_level;
    logic               frame_done;

    modport master (
        output byte_in,
        output pixel_req,
        input  refresh_data,
        input  rgb,
        input  pixel_valid,
        input  underflow,
        input  fifo_level,
        input  frame_done
    );

    modport slave (
        input  byte_in,
        input  pixel_req,
        output refresh_data,
        output rgb,
        output pixel_valid,
        output underflow,
        output fifo_level,
        output frame_done
    );
endinterface
`default_nettype wire

// File: rtl/vga_pixel_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pixel_assembler
//  Description : Requests bytes from the frame-buffer reader (R, G, B per
//                pixel), packs them into 24-bit pixels, buffers them in a
//                small FIFO and pops them for the VGA output stage.
//  Ports       : clk  - clock
//                rst  - synchronous active-high reset
//                bus  - vga_pixel_assembler_if.slave (byte_in, pixel_req in;
//                       refresh_data, rgb, pixel_valid, underflow,
//                       fifo_level, frame_done out)
//  Revision    : 1.0  initial release
// ============================================================================
module vga_pixel_assembler #(
    parameter int REQ_HOLD       = 4,
    parameter int RELEASE_CYCLES = 2,
    parameter int FIFO_DEPTH     = 4,
    parameter int FRAME_PIXELS   = 1024 * 768
) (
    input  wire logic             clk,
    input  wire logic             rst,
    vga_pixel_assembler_if.slave  bus
);
    localparam int ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int LEVEL_W = ADDR_W + 1;
    localparam int FRAME_W = $clog2(FRAME_PIXELS);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    if (REQ_HOLD < 3 || REQ_HOLD > 15) begin : g_chk_req_hold
        $error("vga_pixel_assembler: REQ_HOLD must be in 3..15");
    end
    if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 15) begin : g_chk_release
        $error("vga_pixel_assembler: RELEASE_CYCLES must be in 1..15");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("vga_pixel_assembler: FIFO_DEPTH must be a power of 2, >= 2");
    end
    if (FRAME_PIXELS < 2) begin : g_chk_frame
        $error("vga_pixel_assembler: FRAME_PIXELS must be >= 2");
    end

    // ------------------------------------------------------------------
    // Fetch FSM
    // refresh_data is high for REQ_HOLD cycles: REQ_HOLD-1 cycles in REQ
    // plus the CAPTURE cycle. byte_in is sampled on the edge leaving the
    // last REQ cycle, so one byte takes REQ_HOLD+1+RELEASE_CYCLES cycles
    // including the IDLE decision cycle.
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_CAPTURE = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [7:0]         part_r_q, part_g_q;
    logic               capture;
    logic               push;
    logic               pop;

    logic [23:0]        mem_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LEVEL_W-1:0] count_q;

    logic [23:0]        rgb_q;
    logic               valid_q;
    logic               underflow_q;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               frame_done_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A new pixel only starts when the FIFO has room for it,
                // which is what keeps a push from ever hitting a full FIFO.
                if (idx_q != 2'd0 || count_q < LEVEL_W'(FIFO_DEPTH)) begin
                    state_d = S_REQ;
                    cnt_d   = 4'd0;
                end
            end
            S_REQ: begin
                if (cnt_q == 4'(REQ_HOLD - 2)) begin
                    state_d = S_CAPTURE;
                    capture = 1'b1;
                    idx_d   = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_RELEASE;
                cnt_d   = 4'd0;
            end
            S_RELEASE: begin
                if (cnt_q == 4'(RELEASE_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign push = capture && (idx_q == 2'd2);
    assign pop  = bus.pixel_req && (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= 2'd0;
            part_r_q <= 8'd0;
            part_g_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (capture && idx_q == 2'd0) part_r_q <= bus.byte_in;
            if (capture && idx_q == 2'd1) part_g_q <= bus.byte_in;
        end
    end

    // ------------------------------------------------------------------
    // Pixel FIFO; the blue byte goes straight from byte_in into storage.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {part_r_q, part_g_q, bus.byte_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + LEVEL_W'(1);
                2'b01:   count_q <= count_q - LEVEL_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Pop output stage and frame counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q        <= 24'd0;
            valid_q      <= 1'b0;
            underflow_q  <= 1'b0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            valid_q      <= 1'b0;
            if (bus.pixel_req) begin
                if (count_q != '0) begin
                    rgb_q   <= mem_q[rd_ptr_q];
                    valid_q <= 1'b1;
                end else begin
                    rgb_q       <= 24'd0;
                    underflow_q <= 1'b1;
                end
                // Counts every strobe, valid or not, so frame alignment
                // survives an underflow.
                if (frame_cnt_q == FRAME_W'(FRAME_PIXELS - 1)) begin
                    frame_cnt_q  <= '0;
                    frame_done_q <= 1'b1;
                end else begin
                    frame_cnt_q <= frame_cnt_q + FRAME_W'(1);
                end
            end
        end
    end

    assign bus.refresh_data = (state_q == S_REQ) || (state_q == S_CAPTURE);
    assign bus.rgb          = rgb_q;
    assign bus.pixel_valid  = valid_q;
    assign bus.underflow    = underflow_q;
    assign bus.fifo_level   = count_q;
    assign bus.frame_done   = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_pixel_assembler
//  Description : Self-checking bench for vga_pixel_assembler with a reader
//                model, a per-cycle timeline/queue reference model and
//                directed scenarios with literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_pixel_assembler;
    localparam int REQ_HOLD       = 4;
    localparam int RELEASE_CYCLES = 2;
    localparam int FIFO_DEPTH     = 4;
    localparam int FRAME_PIXELS   = 8;
    localparam int PERIOD         = REQ_HOLD + 1 + RELEASE_CYCLES;

    logic clk;
    logic rst;

    vga_pixel_assembler_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    vga_pixel_assembler #(
        .REQ_HOLD       (REQ_HOLD),
        .RELEASE_CYCLES (RELEASE_CYCLES),
        .FIFO_DEPTH     (FIFO_DEPTH),
        .FRAME_PIXELS   (FRAME_PIXELS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reader model: presents the next stream byte when a request starts.
    // ------------------------------------------------------------------
    logic [7:0] stream [64];
    int         rd_ptr;
    logic       prev_ref = 1'b0;

    always @(negedge clk) begin
        if (bus.refresh_data && !prev_ref) begin
            bus.byte_in = stream[rd_ptr];
            rd_ptr++;
        end
        prev_ref = bus.refresh_data;
    end

    // ------------------------------------------------------------------
    // Reference model. Each byte slot is PERIOD cycles: slot cycle 0 is the
    // start decision, cycles 1..REQ_HOLD have the request high, the byte
    // is taken at the end of slot cycle REQ_HOLD-1. Pixels live in a queue.
    // ------------------------------------------------------------------
    bit          armed = 1'b0;
    int          m_pos, m_idx, m_fcnt;
    logic [7:0]  m_part [3];
    logic [23:0] m_q [$];
    logic        exp_ref, exp_valid, exp_uf, exp_fd;
    logic [23:0] exp_rgb;
    int          exp_level;

    always @(negedge clk) begin
        if (armed) begin
            check("refresh_data", 32'(bus.refresh_data), 32'(exp_ref));
            check("rgb",          32'(bus.rgb),          32'(exp_rgb));
            check("pixel_valid",  32'(bus.pixel_valid),  32'(exp_valid));
            check("underflow",    32'(bus.underflow),    32'(exp_uf));
            check("fifo_level",   32'(bus.fifo_level),   32'(exp_level));
            check("frame_done",   32'(bus.frame_done),   32'(exp_fd));
        end
        if (rst) begin
            armed = 1'b1;
            m_pos = 0; m_idx = 0; m_fcnt = 0;
            m_q.delete();
            exp_ref = 0; exp_valid = 0; exp_uf = 0; exp_fd = 0;
            exp_rgb = 24'd0; exp_level = 0;
        end else if (armed) begin
            int          cur_size;
            bit          do_push;
            logic [23:0] newpix;
            cur_size = m_q.size();
            do_push  = 0;
            newpix   = 24'd0;
            if (m_pos == REQ_HOLD - 1) begin
                m_part[m_idx] = bus.byte_in;
                if (m_idx == 2) begin
                    do_push = 1;
                    newpix  = {m_part[0], m_part[1], m_part[2]};
                    m_idx   = 0;
                end else begin
                    m_idx++;
                end
            end
            exp_fd    = 0;
            exp_valid = 0;
            if (bus.pixel_req) begin
                if (cur_size > 0) begin
                    exp_rgb   = m_q.pop_front();
                    exp_valid = 1;
                end else begin
                    exp_rgb = 24'd0;
                    exp_uf  = 1;
                end
                m_fcnt++;
                if (m_fcnt == FRAME_PIXELS) begin
                    m_fcnt = 0;
                    exp_fd = 1;
                end
            end
            if (do_push) m_q.push_back(newpix);
            if (m_pos == 0) begin
                if (!(m_idx == 0 && cur_size >= FIFO_DEPTH)) m_pos = 1;
            end else begin
                m_pos = (m_pos == PERIOD - 1) ? 0 : m_pos + 1;
            end
            exp_ref   = (m_pos >= 1 && m_pos <= REQ_HOLD);
            exp_level = m_q.size();
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog timeout");
    end

    // ------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------
    initial begin
        int cyc;
        int hi;
        int pulses;

        for (int i = 0; i < 64; i++) stream[i] = 8'(i);
        stream[0]  = 8'h11; stream[1]  = 8'h22; stream[2]  = 8'h33;
        stream[3]  = 8'h44; stream[4]  = 8'h55; stream[5]  = 8'h66;
        stream[6]  = 8'h77; stream[7]  = 8'h88; stream[8]  = 8'h99;
        stream[9]  = 8'hAA; stream[10] = 8'hBB; stream[11] = 8'hCC;
        stream[12] = 8'hDD; stream[13] = 8'hEE; stream[14] = 8'hF0;
        stream[30] = 8'hA1; stream[31] = 8'hB2; stream[32] = 8'hC3;

        rst           = 1'b1;
        bus.pixel_req = 1'b0;
        bus.byte_in   = 8'h00;
        rd_ptr        = 0;
        repeat (3) step();
        rst = 1'b0;

        // Cycle 0 after reset: reset values.
        check("rst_refresh",    32'(bus.refresh_data), 32'd0);
        check("rst_rgb",        32'(bus.rgb),          32'd0);
        check("rst_valid",      32'(bus.pixel_valid),  32'd0);
        check("rst_underflow",  32'(bus.underflow),    32'd0);
        check("rst_level",      32'(bus.fifo_level),   32'd0);
        check("rst_frame_done", 32'(bus.frame_done),   32'd0);

        // Empty pop right after reset.
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("uf_valid", 32'(bus.pixel_valid), 32'd0);
        check("uf_rgb",   32'(bus.rgb),         32'd0);
        check("uf_flag",  32'(bus.underflow),   32'd1);

        // First pixel: bytes taken at ends of cycles 3, 10, 17 -> level 1 in cycle 18.
        cyc = 1;
        while (bus.fifo_level != 1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("first_pixel_cycle", 32'(cyc), 32'd18);
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("pop1_rgb",       32'(bus.rgb),         32'h112233);
        check("pop1_valid",     32'(bus.pixel_valid), 32'd1);
        check("pop1_underflow", 32'(bus.underflow),   32'd1);

        // Fill to FIFO_DEPTH, then fetching must stall.
        cyc = 0;
        while (bus.fifo_level != FIFO_DEPTH && cyc < 300) begin
            step();
            cyc++;
        end
        check("fill_reached", 32'(bus.fifo_level), 32'(FIFO_DEPTH));
        hi = 0;
        repeat (30) begin
            step();
            if (bus.refresh_data) hi++;
        end
        check("stall_refresh_cycles", 32'(hi), 32'd0);
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("resume_level",   32'(bus.fifo_level),   32'd3);
        check("resume_rgb",     32'(bus.rgb),          32'h445566);
        check("resume_ref_low", 32'(bus.refresh_data), 32'd0);
        step();
        check("resume_ref_high", 32'(bus.refresh_data), 32'd1);

        // Bring level to 2, then pop on the push edge.
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("pre_sim_rgb", 32'(bus.rgb), 32'h778899);
        cyc = 0;
        while (!(m_pos == REQ_HOLD - 1 && m_idx == 2) && cyc < 100) begin
            step();
            cyc++;
        end
        check("sim_level_before", 32'(bus.fifo_level), 32'd2);
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("sim_level_after", 32'(bus.fifo_level),  32'd2);
        check("sim_rgb",         32'(bus.rgb),         32'hAABBCC);
        check("sim_valid",       32'(bus.pixel_valid), 32'd1);

        // Frame counter with FRAME_PIXELS = 8.
        rst    = 1'b1;
        rd_ptr = 0;
        step();
        rst = 1'b0;
        check("uf_cleared_by_rst", 32'(bus.underflow), 32'd0);
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            bus.pixel_req = 1'b1;
            step();
            bus.pixel_req = 1'b0;
            check($sformatf("frame_done_strobe%0d", i), 32'(bus.frame_done),
                  (i == 8 || i == 16) ? 32'd1 : 32'd0);
            if (bus.frame_done) pulses++;
            step();
        end
        check("frame_pulses", 32'(pulses), 32'd2);

        // Reset while fetching the second byte of a pixel.
        rst    = 1'b1;
        rd_ptr = 0;
        step();
        rst = 1'b0;
        cyc = 0;
        while (!(m_idx == 1 && m_pos == 2) && cyc < 100) begin
            step();
            cyc++;
        end
        check("midfetch_ref_before", 32'(bus.refresh_data), 32'd1);
        rst    = 1'b1;
        rd_ptr = 30;
        step();
        rst = 1'b0;
        check("midfetch_ref", 32'(bus.refresh_data), 32'd0);
        check("midfetch_lvl", 32'(bus.fifo_level),   32'd0);
        cyc = 0;
        while (bus.fifo_level != 1 && cyc < 100) begin
            step();
            cyc++;
        end
        check("fresh_pixel_cycle", 32'(cyc), 32'd18);
        bus.pixel_req = 1'b1;
        step();
        bus.pixel_req = 1'b0;
        check("fresh_rgb",   32'(bus.rgb),         32'hA1B2C3);
        check("fresh_valid", 32'(bus.pixel_valid), 32'd1);

        repeat (5) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
